// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with synchronous clear, parallel load, prescaler and
// wrap or saturate behaviour at the range ends; tc supports cascading stages.
module counter_updown_mod #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 32'sd1 << WIDTH,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             sat_hit,
    output logic             load_err
);

    localparam int             PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX      = WIDTH'(MODULUS - 32'sd1);
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(32'sd1);
    localparam logic [PW-1:0]  LAST_PHASE = PW'(PRESCALE - 32'sd1);
    localparam logic [PW-1:0]  PHASE_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]  PHASE_ONE  = PW'(32'sd1);

    if (WIDTH < 1) begin : g_bad_width
        $error("counter_updown_mod: WIDTH must be >= 1");
    end
    if ((MODULUS < 2) || ((WIDTH < 32) && (64'(MODULUS) > (64'sd1 << WIDTH)))) begin : g_bad_modulus
        $error("counter_updown_mod: MODULUS must be within 2..2**WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("counter_updown_mod: PRESCALE must be >= 1");
    end

    logic [WIDTH-1:0] count_r;
    logic [PW-1:0]    phase_r;
    logic             wrap_r;
    logic             sat_hit_r;
    logic             load_err_r;

    logic [WIDTH-1:0] count_nxt_s;
    logic [PW-1:0]    phase_nxt_s;
    logic             wrap_nxt_s;
    logic             sat_hit_nxt_s;
    logic             load_err_nxt_s;
    logic             step_s;
    logic             tc_s;

    // Prescaler terminal phase and the cascade-out decode of the live count.
    always_comb begin
        step_s = (phase_r == LAST_PHASE);
        if (up) begin
            tc_s = en & step_s & ~clr & ~load & (count_r == MAX);
        end else begin
            tc_s = en & step_s & ~clr & ~load & (count_r == ZERO);
        end
    end

    // Next-state selection with clr > load > en priority.
    always_comb begin
        count_nxt_s    = count_r;
        phase_nxt_s    = phase_r;
        wrap_nxt_s     = 1'b0;
        sat_hit_nxt_s  = 1'b0;
        load_err_nxt_s = 1'b0;
        if (clr) begin
            count_nxt_s = ZERO;
            phase_nxt_s = PHASE_ZERO;
        end else if (load) begin
            phase_nxt_s = PHASE_ZERO;
            if (load_val > MAX) begin
                count_nxt_s    = MAX;
                load_err_nxt_s = 1'b1;
            end else begin
                count_nxt_s = load_val;
            end
        end else if (en) begin
            if (step_s) begin
                phase_nxt_s = PHASE_ZERO;
                if (up) begin
                    if (count_r != MAX) begin
                        count_nxt_s = count_r + ONE;
                    end else if (SATURATE != 0) begin
                        sat_hit_nxt_s = 1'b1;
                    end else begin
                        count_nxt_s = ZERO;
                        wrap_nxt_s  = 1'b1;
                    end
                end else begin
                    if (count_r != ZERO) begin
                        count_nxt_s = count_r - ONE;
                    end else if (SATURATE != 0) begin
                        sat_hit_nxt_s = 1'b1;
                    end else begin
                        count_nxt_s = MAX;
                        wrap_nxt_s  = 1'b1;
                    end
                end
            end else begin
                phase_nxt_s = phase_r + PHASE_ONE;
            end
        end else begin
            count_nxt_s = count_r;
            phase_nxt_s = phase_r;
        end
    end

    // State and pulse registers; reset acts immediately without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r    <= ZERO;
            phase_r    <= PHASE_ZERO;
            wrap_r     <= 1'b0;
            sat_hit_r  <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            count_r    <= count_nxt_s;
            phase_r    <= phase_nxt_s;
            wrap_r     <= wrap_nxt_s;
            sat_hit_r  <= sat_hit_nxt_s;
            load_err_r <= load_err_nxt_s;
        end
    end

    assign count    = count_r;
    assign tc       = tc_s;
    assign wrap     = wrap_r;
    assign sat_hit  = sat_hit_r;
    assign load_err = load_err_r;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: wrap, saturate, load, prescale,
// asynchronous reset and a two-digit decimal cascade.
module tb_counter_updown_mod;

    logic       clk;
    logic       reset;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       up;
    logic       casc_en;

    logic [3:0] cnt_d, cnt_s, cnt_p, cnt_u, cnt_t;
    logic       tc_d, tc_s, tc_p, tc_u, tc_t;
    logic       wrap_d, wrap_s, wrap_p, wrap_u, wrap_t;
    logic       sat_d, sat_s, sat_p, sat_u, sat_t;
    logic       lerr_d, lerr_s, lerr_p, lerr_u, lerr_t;

    int passed;
    int failed;
    int total;
    int exp_cnt;

    counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_dut (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(cnt_d), .tc(tc_d), .wrap(wrap_d),
        .sat_hit(sat_d), .load_err(lerr_d));

    counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) u_sat (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(cnt_s), .tc(tc_s), .wrap(wrap_s),
        .sat_hit(sat_s), .load_err(lerr_s));

    counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3)) u_pre (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .count(cnt_p), .tc(tc_p), .wrap(wrap_p),
        .sat_hit(sat_p), .load_err(lerr_p));

    counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_units (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(casc_en), .up(up), .count(cnt_u), .tc(tc_u), .wrap(wrap_u),
        .sat_hit(sat_u), .load_err(lerr_u));

    counter_updown_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_tens (
        .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
        .en(tc_u), .up(up), .count(cnt_t), .tc(tc_t), .wrap(wrap_t),
        .sat_hit(sat_t), .load_err(lerr_t));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        passed = 0; failed = 0; total = 0;
        reset = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0;
        en = 1'b0; up = 1'b1; casc_en = 1'b0;
        #12;
        reset = 1'b0;
        chk("rst_cnt_d", 32'(cnt_d), 32'd0);
        chk("rst_cnt_s", 32'(cnt_s), 32'd0);
        chk("rst_cnt_p", 32'(cnt_p), 32'd0);
        chk("rst_pulses", 32'({wrap_d, sat_s, lerr_d}), 32'd0);

        // wrap mode counting up through the range end
        en = 1'b1; up = 1'b1; #1;
        exp_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            chk("t1_tc", 32'(tc_d), 32'(exp_cnt == 9));
            tick();
            exp_cnt = (exp_cnt + 1) % 10;
            chk("t1_cnt", 32'(cnt_d), 32'(exp_cnt));
            chk("t1_wrap", 32'(wrap_d), 32'(exp_cnt == 0));
        end

        // counting down from 0 wraps to 9
        clr = 1'b1; tick();
        chk("t2_clr_cnt", 32'(cnt_d), 32'd0);
        chk("t2_clr_wrap", 32'(wrap_d), 32'd0);
        clr = 1'b0; up = 1'b0; #1;
        chk("t2_tc0", 32'(tc_d), 32'd1);
        tick();
        chk("t2_cnt9", 32'(cnt_d), 32'd9);
        chk("t2_wrap9", 32'(wrap_d), 32'd1);
        chk("t2_tc9", 32'(tc_d), 32'd0);
        tick();
        chk("t2_cnt8", 32'(cnt_d), 32'd8);
        chk("t2_wrap8", 32'(wrap_d), 32'd0);
        tick();
        chk("t2_cnt7", 32'(cnt_d), 32'd7);

        // saturate mode at both ends
        clr = 1'b1; up = 1'b1; tick();
        clr = 1'b0; #1;
        for (int i = 0; i < 9; i++) tick();
        chk("t3_cnt9", 32'(cnt_s), 32'd9);
        chk("t3_nosat", 32'(sat_s), 32'd0);
        chk("t3_tc", 32'(tc_s), 32'd1);
        tick();
        chk("t3_hold1", 32'(cnt_s), 32'd9);
        chk("t3_sat1", 32'(sat_s), 32'd1);
        chk("t3_nowrap1", 32'(wrap_s), 32'd0);
        tick();
        chk("t3_hold2", 32'(cnt_s), 32'd9);
        chk("t3_sat2", 32'(sat_s), 32'd1);
        clr = 1'b1; tick();
        chk("t3_clr_cnt", 32'(cnt_s), 32'd0);
        chk("t3_clr_sat", 32'(sat_s), 32'd0);
        clr = 1'b0; up = 1'b0; #1;
        chk("t3_tc_dn", 32'(tc_s), 32'd1);
        tick();
        chk("t3_hold0", 32'(cnt_s), 32'd0);
        chk("t3_sat_dn", 32'(sat_s), 32'd1);
        chk("t3_nowrap_dn", 32'(wrap_s), 32'd0);
        tick();
        chk("t3_sat_dn2", 32'(sat_s), 32'd1);

        // parallel load, clamp and priority
        en = 1'b0; load = 1'b1; load_val = 4'd7; tick();
        chk("t4_ld7", 32'(cnt_d), 32'd7);
        chk("t4_ld7_err", 32'(lerr_d), 32'd0);
        load_val = 4'd9; tick();
        chk("t4_ld9", 32'(cnt_d), 32'd9);
        chk("t4_ld9_err", 32'(lerr_d), 32'd0);
        load_val = 4'd12; tick();
        chk("t4_ld12", 32'(cnt_d), 32'd9);
        chk("t4_ld12_err", 32'(lerr_d), 32'd1);
        load = 1'b0; tick();
        chk("t4_hold", 32'(cnt_d), 32'd9);
        chk("t4_err_clr", 32'(lerr_d), 32'd0);
        clr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; #1;
        chk("t4_tc_clr", 32'(tc_d), 32'd0);
        tick();
        chk("t4_pri_cnt", 32'(cnt_d), 32'd0);
        chk("t4_pri_pulses", 32'({wrap_d, sat_d, lerr_d}), 32'd0);
        clr = 1'b0; load = 1'b0; en = 1'b0;

        // prescaler by 3 with enable gaps and direction change
        clr = 1'b1; en = 1'b1; up = 1'b1; tick();
        clr = 1'b0;
        tick(); chk("t5_e1", 32'(cnt_p), 32'd0);
        tick(); chk("t5_e2", 32'(cnt_p), 32'd0);
        tick(); chk("t5_e3", 32'(cnt_p), 32'd1);
        tick(); chk("t5_e4", 32'(cnt_p), 32'd1);
        en = 1'b0;
        tick(); chk("t5_gap1", 32'(cnt_p), 32'd1);
        tick(); chk("t5_gap2", 32'(cnt_p), 32'd1);
        en = 1'b1;
        tick(); chk("t5_res1", 32'(cnt_p), 32'd1);
        tick(); chk("t5_res2", 32'(cnt_p), 32'd2);
        tick(); chk("t5_dir1", 32'(cnt_p), 32'd2);
        up = 1'b0;
        tick(); chk("t5_dir2", 32'(cnt_p), 32'd2);
        tick(); chk("t5_dir3", 32'(cnt_p), 32'd1);

        // asynchronous reset between edges
        clr = 1'b1; up = 1'b1; tick();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t6_cnt5", 32'(cnt_d), 32'd5);
        reset = 1'b1; #1;
        chk("t6_async", 32'(cnt_d), 32'd0);
        #2;
        reset = 1'b0;
        tick();
        chk("t6_first", 32'(cnt_d), 32'd1);

        // two-digit decimal cascade through tc
        en = 1'b0; casc_en = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            chk("t6_casc", 32'(cnt_t) * 32'd10 + 32'(cnt_u), 32'(i % 100));
        end
        casc_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
